// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the queued note sequencer:
//   - default keycode constants (stop key)
//   - handshake and player state encodings
//   - helper to size counters from their terminal count
// -----------------------------------------------------------------------------
package synth_pkg;

   localparam int KEY_W_DEF    = 4;
   localparam int KEY_STOP_DEF = 15;

   localparam int PLAY_STATE_W = 3;

   // Keycode handshake with the keyboard decoder.
   typedef enum logic {
      H_REQ      = 1'b0,
      H_WAIT_LOW = 1'b1
   } hs_state_t;

   // Note player / envelope sequencer.
   typedef enum logic [PLAY_STATE_W-1:0] {
      P_IDLE    = 3'd0,
      P_ATTACK  = 3'd1,
      P_SUSTAIN = 3'd2,
      P_RELEASE = 3'd3,
      P_GAP     = 3'd4
   } play_state_t;

   // Width of a counter running 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/synth_note_fifo.sv
// -----------------------------------------------------------------------------
// synth_note_fifo
// Synchronous FIFO holding one-hot note words.
// Ports:
//   CLOCK_50  in   clock
//   reset     in   synchronous, active-high; empties the FIFO
//   i_push    in   write i_data (ignored when full, unless popping too)
//   i_data    in   W-bit entry
//   i_pop     in   discard head (ignored when empty)
//   i_flush   in   empty the FIFO; overrides push and pop in the same cycle
//   o_head    out  oldest entry (valid when !o_empty)
//   o_full    out  DEPTH entries stored
//   o_empty   out  no entries stored
//   o_level   out  occupancy 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module synth_note_fifo #(
   parameter int W     = 7,
   parameter int DEPTH = 4
) (
   input  logic                     CLOCK_50,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [W-1:0]             i_data,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic [W-1:0]             o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;

   logic w_do_push;
   logic w_do_pop;

   assign o_full  = (r_level == LW'(DEPTH));
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_head  = r_mem[r_rd_ptr];

   // A full FIFO may still accept a push when the head leaves in the same cycle.
   assign w_do_pop  = i_pop  && !i_flush && !o_empty;
   assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

   always_ff @(posedge CLOCK_50) begin
      if (reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_do_push && !w_do_pop)      r_level <= r_level + LW'(1);
         else if (!w_do_push && w_do_pop) r_level <= r_level - LW'(1);
      end
   end

   // Storage needs no reset: contents are only read behind a non-zero level.
   always_ff @(posedge CLOCK_50) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/synth_note_sequencer.sv
// -----------------------------------------------------------------------------
// synth_note_sequencer
// Queued, enveloped note player for the tone generator. Keycodes arrive over
// a four-phase handshake, are queued as one-hot notes, and each note is played
// for SND_LEN cycles of attack+sustain, followed by a linear release and a
// silent gap.
// Ports:
//   CLOCK_50        in   system clock
//   reset           in   synchronous, active-high
//   i_keycode       in   key from keyboard decoder, valid while i_data_ready
//   i_data_ready    in   producer has a keycode
//   o_data_request  out  block can accept a keycode (registered)
//   o_note          out  one-hot note, 0 = silent
//   o_volume        out  amplitude
//   o_busy          out  player not idle
//   o_queue_level   out  FIFO occupancy
//   o_drop_count    out  saturating count of invalid keycodes
//   o_hs_state      out  handshake FSM state (debug)
//   o_play_state    out  player FSM state (debug)
// -----------------------------------------------------------------------------
module synth_note_sequencer
   import synth_pkg::*;
#(
   parameter int NUM_NOTES  = 7,
   parameter int KEY_W      = KEY_W_DEF,
   parameter int KEY_STOP   = KEY_STOP_DEF,
   parameter int SND_LEN    = 100000000,
   parameter int RAMP_CYC   = 500000,
   parameter int VOL_W      = 4,
   parameter int GAP_LEN    = 2500000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        CLOCK_50,
   input  logic                        reset,
   input  logic [KEY_W-1:0]            i_keycode,
   input  logic                        i_data_ready,
   output logic                        o_data_request,
   output logic [NUM_NOTES-1:0]        o_note,
   output logic [VOL_W-1:0]            o_volume,
   output logic                        o_busy,
   output logic [$clog2(FIFO_DEPTH):0] o_queue_level,
   output logic [7:0]                  o_drop_count,
   output logic                        o_hs_state,
   output logic [PLAY_STATE_W-1:0]     o_play_state
);

   localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int RAMP_W = cnt_w(RAMP_CYC);
   localparam int GAP_W  = cnt_w(GAP_LEN);

   localparam logic [VOL_W-1:0]     VOL_MAX  = '1;
   localparam logic [VOL_W-1:0]     VOL_ONE  = VOL_W'(1);
   localparam logic [KEY_W-1:0]     KEY_ONE  = KEY_W'(1);
   localparam logic [NUM_NOTES-1:0] NOTE_LSB = NUM_NOTES'(1);

   // ------------------------------------------------------------------------
   // Handshake
   // Four-phase: o_data_request high means one keycode may be offered. A
   // keycode is taken on the edge where o_data_request and i_data_ready are
   // both high; o_data_request then stays low until i_data_ready has been
   // seen low, so a held i_data_ready yields exactly one capture.
   // ------------------------------------------------------------------------
   hs_state_t r_hs_state, w_hs_next;
   logic      r_data_request;
   logic [7:0] r_drop_count;

   logic                 w_capture;
   logic                 w_key_note;
   logic                 w_key_stop;
   logic                 w_push;
   logic                 w_stop;
   logic                 w_drop;
   logic                 w_pop;
   logic [NUM_NOTES-1:0] w_onehot;

   logic [NUM_NOTES-1:0] w_head;
   logic                 w_full;
   logic                 w_empty;
   logic [LVL_W-1:0]     w_level;
   logic [LVL_W-1:0]     w_level_next;

   assign w_capture  = (r_hs_state == H_REQ) && r_data_request && i_data_ready && !w_full;
   assign w_key_stop = (i_keycode == KEY_W'(KEY_STOP));
   assign w_key_note = (i_keycode != '0) && (i_keycode <= KEY_W'(NUM_NOTES));
   assign w_onehot   = NOTE_LSB << (i_keycode - KEY_ONE);

   // Stop takes priority in case a build ever maps it inside the note range.
   assign w_stop = w_capture && w_key_stop;
   assign w_push = w_capture && !w_key_stop && w_key_note;
   assign w_drop = w_capture && !w_key_stop && !w_key_note;

   always_comb begin
      w_hs_next = r_hs_state;
      case (r_hs_state)
         H_REQ:      if (w_capture) w_hs_next = H_WAIT_LOW;
         H_WAIT_LOW: if (!i_data_ready) w_hs_next = H_REQ;
         default:    w_hs_next = H_REQ;
      endcase
   end

   // Occupancy after this edge; lets o_data_request be registered yet still
   // drop on the very edge that fills the FIFO.
   always_comb begin
      w_level_next = w_level;
      if (w_stop)               w_level_next = '0;
      else if (w_push && !w_pop) w_level_next = w_level + LVL_W'(1);
      else if (!w_push && w_pop) w_level_next = w_level - LVL_W'(1);
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_hs_state     <= H_REQ;
         r_data_request <= 1'b0;
         r_drop_count   <= '0;
      end else begin
         r_hs_state     <= w_hs_next;
         r_data_request <= (w_hs_next == H_REQ) && (w_level_next != LVL_W'(FIFO_DEPTH));
         if (w_drop && (r_drop_count != 8'hFF))
            r_drop_count <= r_drop_count + 8'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Note queue
   // ------------------------------------------------------------------------
   synth_note_fifo #(
      .W     (NUM_NOTES),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .i_push   (w_push),
      .i_data   (w_onehot),
      .i_pop    (w_pop),
      .i_flush  (w_stop),
      .o_head   (w_head),
      .o_full   (w_full),
      .o_empty  (w_empty),
      .o_level  (w_level)
   );

   // ------------------------------------------------------------------------
   // Player / envelope
   // ------------------------------------------------------------------------
   play_state_t          r_play_state, w_play_next;
   logic [NUM_NOTES-1:0] r_note,       w_note_next;
   logic [VOL_W-1:0]     r_volume,     w_vol_next;
   logic [31:0]          r_dur_cnt,    w_dur_next;
   logic [RAMP_W-1:0]    r_ramp_cnt,   w_ramp_next;
   logic [GAP_W-1:0]     r_gap_cnt,    w_gap_next;

   logic w_ramp_tick;

   // A stop flushes the queue, so nothing may be popped in that cycle.
   assign w_pop       = (r_play_state == P_IDLE) && !w_empty && !w_stop;
   assign w_ramp_tick = (r_ramp_cnt == RAMP_W'(RAMP_CYC - 1));

   always_comb begin
      w_play_next = r_play_state;
      w_note_next = r_note;
      w_vol_next  = r_volume;
      w_dur_next  = r_dur_cnt;
      w_ramp_next = r_ramp_cnt;
      w_gap_next  = r_gap_cnt;
      case (r_play_state)
         P_IDLE: begin
            if (w_pop) begin
               w_play_next = P_ATTACK;
               w_note_next = w_head;
               w_vol_next  = '0;
               w_dur_next  = '0;
               w_ramp_next = '0;
            end
         end
         P_ATTACK, P_SUSTAIN: begin
            w_dur_next = r_dur_cnt + 32'd1;
            if (r_play_state == P_ATTACK) begin
               if (w_ramp_tick) begin
                  w_ramp_next = '0;
                  w_vol_next  = r_volume + VOL_ONE;
                  if (r_volume == (VOL_MAX - VOL_ONE)) w_play_next = P_SUSTAIN;
               end else begin
                  w_ramp_next = r_ramp_cnt + RAMP_W'(1);
               end
            end
            // End of the note or a stop: release from whatever level was reached.
            if (w_stop || (r_dur_cnt == 32'(SND_LEN - 1))) begin
               w_play_next = P_RELEASE;
               w_vol_next  = r_volume;
               w_ramp_next = '0;
            end
         end
         P_RELEASE: begin
            if (r_volume == '0) begin
               // Stopped before the first attack step: nothing to ramp down.
               w_play_next = P_GAP;
               w_note_next = '0;
               w_gap_next  = '0;
            end else if (w_ramp_tick) begin
               w_ramp_next = '0;
               w_vol_next  = r_volume - VOL_ONE;
               if (r_volume == VOL_ONE) begin
                  w_play_next = P_GAP;
                  w_note_next = '0;
                  w_gap_next  = '0;
               end
            end else begin
               w_ramp_next = r_ramp_cnt + RAMP_W'(1);
            end
         end
         P_GAP: begin
            if (r_gap_cnt == GAP_W'(GAP_LEN - 1)) begin
               w_play_next = P_IDLE;
               w_gap_next  = '0;
            end else begin
               w_gap_next = r_gap_cnt + GAP_W'(1);
            end
         end
         default: begin
            w_play_next = P_IDLE;
            w_note_next = '0;
            w_vol_next  = '0;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_play_state <= P_IDLE;
         r_note       <= '0;
         r_volume     <= '0;
         r_dur_cnt    <= '0;
         r_ramp_cnt   <= '0;
         r_gap_cnt    <= '0;
      end else begin
         r_play_state <= w_play_next;
         r_note       <= w_note_next;
         r_volume     <= w_vol_next;
         r_dur_cnt    <= w_dur_next;
         r_ramp_cnt   <= w_ramp_next;
         r_gap_cnt    <= w_gap_next;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign o_data_request = r_data_request;
   assign o_note         = r_note;
   assign o_volume       = r_volume;
   assign o_busy         = (r_play_state != P_IDLE);
   assign o_queue_level  = w_level;
   assign o_drop_count   = r_drop_count;
   assign o_hs_state     = r_hs_state;
   assign o_play_state   = r_play_state;

endmodule
